pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the pipelined core. It replaces the single-cycle PC unit. It owns the fetch PC and issues fetch requests to the IFU over a valid/ready handshake. It predicts taken control flow with a small direct-mapped BTB and accepts prioritised redirects from trap/interrupt logic and from the execute stage.

## Interface
- XLEN, 64, data/address width (32 or 64)
- START_ADDR, XLEN'h8000_0000, PC value after reset
- BTB_ENTRIES, 8, BTB depth; power of 2, ≥2; IDX = log2(BTB_ENTRIES)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  out  1  fetch request valid
- req_ready  in  1  IFU accepts request
- req_pc  out  XLEN  fetch address
- req_pred_taken  out  1  BTB hit for req_pc
- req_pred_target  out  XLEN  predicted next PC (BTB target or req_pc+4)
- trap_valid  in  1  trap/interrupt/mret redirect
- trap_target  in  XLEN  mtvec/mepc value
- ex_redir_valid  in  1  execute-stage misprediction redirect
- ex_redir_target  in  XLEN  resolved target
- upd_valid  in  1  BTB update strobe from execute
- upd_pc  in  XLEN  PC of resolved branch/jump
- upd_target  in  XLEN  resolved target
- upd_taken  in  1  branch/jump resolved taken
- flush  out  1  one-cycle pulse: younger in-flight fetches must be dropped

## Operation
- State: pc register (XLEN); req_valid flop; BTB arrays valid[BTB_ENTRIES], tag[XLEN-IDX-2], target[XLEN].
- Lookup (combinational on pc): index = pc[IDX+1:2], tag = pc[XLEN-1:IDX+2]. Hit = valid[index] && tag match. req_pred_taken = hit. req_pred_target = hit ? target[index] : pc+4.
- pc+4 wraps modulo 2^XLEN; no overflow flag.
- Next-pc priority, highest first:
  1. trap_valid → trap_target
  2. ex_redir_valid → ex_redir_target
  3. fire (req_valid && req_ready) → req_pred_target
  4. otherwise hold
- All redirect targets have bits [1:0] forced to 0 before loading.
- Redirect (trap_valid or ex_redir_valid): flush=1 in the same cycle (combinational). pc loads the target next cycle. req_valid stays 1.
  - Redirect while req_valid && !req_ready: req_pc changes to the target next cycle. This is the only permitted change of req_pc while valid is unaccepted.
  - Redirect in the same cycle as a fire: the fired request still counts as issued. The IFU discards it via flush.
- Without a redirect, req_pc and req_valid are stable while req_valid && !req_ready.
- BTB update on upd_valid, at index/tag derived from upd_pc:
  - upd_taken=1: write valid=1, tag, target.
  - upd_taken=0 and the entry tag matches: clear valid.
  - upd_taken=0 and the tag mismatches: no change.
- Writes land at the clock edge. A same-cycle lookup of the same index returns the old contents.

## Timing
- Reset (rst=1 at a clk edge):
  - pc=START_ADDR, req_valid=0, all BTB valid=0.
  - Outputs during and after reset: req_pc=START_ADDR, req_pred_taken=0, req_pred_target=START_ADDR+4.
  - flush = trap_valid || ex_redir_valid. It is combinational and not gated by rst.
- First cycle after rst deasserts: req_valid=1.
- Throughput: one request per cycle while req_ready=1. The PC advance to a predicted target has zero bubbles.
- Redirect-to-request latency: 1 cycle (target appears on req_pc the cycle after redirect).
- rst asserted mid-operation: overrides redirects, updates and fire. Registered state returns to reset values at that edge.
- Simultaneous trap_valid and ex_redir_valid: trap wins. flush is still a single pulse.
- Simultaneous upd_valid and redirect: both take effect.

## Test plan
- Reset then req_ready=1 for 4 cycles → req_pc 0x8000_0000, …_0004, …_0008, …_000C; req_pred_taken=0.
- upd_valid with upd_pc=0x8000_0008, upd_target=0x8000_0100, taken=1; then rerun from reset-free redirect to 0x8000_0000 → after …_0004, req_pc=…_0008 with pred_taken=1, then 0x8000_0100.
- req_ready=0 for 3 cycles → req_pc and req_valid held. Then ex_redir to 0x8000_0203 while stalled → flush=1, next req_pc=0x8000_0200.
- trap_valid (target 0x8000_0040) and ex_redir_valid (0x8000_0300) in the same cycle → req_pc=0x8000_0040, one flush pulse.
- upd taken=0 on a hitting entry → that PC is no longer predicted. Aliasing entry (same index, different tag) with taken=0 → entry retained.
- XLEN=32, pc=0xFFFF_FFFC fire → req_pc wraps to 0x0000_0000. rst asserted mid-stream → req_pc=START_ADDR, req_valid=0, BTB empty.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: owns the fetch PC and issues fetch requests over valid/ready, predicting taken
// flow with a direct-mapped BTB and taking trap/execute redirects (trap highest).
module pc_gen #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] START_ADDR  = XLEN'(32'h8000_0000),
  parameter int              BTB_ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_pc,
  output logic            req_pred_taken,
  output logic [XLEN-1:0] req_pred_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            ex_redir_valid,
  input  logic [XLEN-1:0] ex_redir_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  output logic            flush
);

  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            vld_q;

  logic [BTB_ENTRIES-1:0] btb_vld;
  logic [TAGW-1:0]        btb_tag [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt [BTB_ENTRIES];

  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;
  logic [XLEN-1:0] pc_plus4;

  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_tag_match;

  logic fire;
  logic redirect;

  // Address bits below word alignment are never consumed.
  logic unused_low_bits;
  assign unused_low_bits = ^{trap_target[1:0], ex_redir_target[1:0], upd_pc[1:0]};

  // Lookup reads the pre-edge array contents, so a same-cycle update is not visible.
  assign lk_idx   = pc_q[IDX+1:2];
  assign lk_tag   = pc_q[XLEN-1:IDX+2];
  assign lk_hit   = btb_vld[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign pc_plus4 = pc_q + XLEN'(4);

  assign up_idx       = upd_pc[IDX+1:2];
  assign up_tag       = upd_pc[XLEN-1:IDX+2];
  assign up_tag_match = (btb_tag[up_idx] == up_tag);

  assign fire     = vld_q && req_ready;
  assign redirect = trap_valid || ex_redir_valid;

  assign req_valid       = vld_q;
  assign req_pc          = pc_q;
  assign req_pred_taken  = lk_hit;
  assign req_pred_target = lk_hit ? btb_tgt[lk_idx] : pc_plus4;
  assign flush           = redirect;

  always_comb begin
    pc_d = pc_q;
    if (trap_valid) begin
      pc_d = {trap_target[XLEN-1:2], 2'b00};
    end else if (ex_redir_valid) begin
      pc_d = {ex_redir_target[XLEN-1:2], 2'b00};
    end else if (fire) begin
      pc_d = req_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= START_ADDR;
      vld_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      vld_q <= 1'b1;
    end
  end

  // Not-taken updates only invalidate the entry they own; an aliasing PC leaves it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      btb_vld <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        btb_vld[up_idx] <= 1'b1;
      end else if (up_tag_match) begin
        btb_vld[up_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      btb_tag[up_idx] <= up_tag;
      btb_tgt[up_idx] <= upd_target;
    end
  end

  a_hold_stalled : assert property (@(posedge clk) disable iff (rst)
    (vld_q && !req_ready && !redirect) |=> (vld_q && $stable(pc_q)));

  a_fire_advance : assert property (@(posedge clk) disable iff (rst)
    (fire && !redirect) |=> (pc_q == $past(req_pred_target)));

  a_reset_idle : assert property (@(posedge clk) rst |=> !vld_q);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a queue-and-array reference model predicts every cycle's
// outputs, a negedge monitor compares; a 32-bit instance covers PC wrap.
module tb_pc_gen;

  localparam logic [63:0] START = 64'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit DUT
  logic        rst, req_ready, trap_valid, ex_redir_valid, upd_valid, upd_taken;
  logic [63:0] trap_target, ex_redir_target, upd_pc, upd_target;
  logic        req_valid, req_pred_taken, flush;
  logic [63:0] req_pc, req_pred_target;

  pc_gen #(.XLEN(64), .START_ADDR(64'h8000_0000), .BTB_ENTRIES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .req_pred_taken(req_pred_taken), .req_pred_target(req_pred_target),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .ex_redir_valid(ex_redir_valid), .ex_redir_target(ex_redir_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .flush(flush)
  );

  // 32-bit DUT
  logic        rst32, ready32, ex32_valid;
  logic [31:0] ex32_target;
  logic        v32, pt32, fl32;
  logic [31:0] pc32, ptg32;

  pc_gen #(.XLEN(32), .START_ADDR(32'h8000_0000), .BTB_ENTRIES(8)) dut32 (
    .clk(clk), .rst(rst32),
    .req_valid(v32), .req_ready(ready32), .req_pc(pc32),
    .req_pred_taken(pt32), .req_pred_target(ptg32),
    .trap_valid(1'b0), .trap_target(32'h0),
    .ex_redir_valid(ex32_valid), .ex_redir_target(ex32_target),
    .upd_valid(1'b0), .upd_pc(32'h0), .upd_target(32'h0), .upd_taken(1'b0),
    .flush(fl32)
  );

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: BTB kept as "which PC owns each slot" plus its target.
  logic [63:0] m_pc;
  logic        m_vld;
  logic [63:0] m_bpc  [int];
  logic [63:0] m_btgt [int];

  function automatic int slot(input logic [63:0] a);
    return int'((a >> 2) % 64'd8);
  endfunction

  function automatic bit owns(input logic [63:0] a);
    int k = slot(a);
    return m_bpc.exists(k) && ((m_bpc[k] >> 2) == (a >> 2));
  endfunction

  function automatic logic [63:0] m_next_fetch();
    return owns(m_pc) ? m_btgt[slot(m_pc)] : m_pc + 64'd4;
  endfunction

  task automatic model_step();
    logic [63:0] nxt;
    int k;
    if (rst) begin
      m_pc  = START;
      m_vld = 1'b0;
      m_bpc.delete();
      m_btgt.delete();
    end else begin
      nxt = m_pc;
      if (trap_valid)               nxt = trap_target & ~64'd3;
      else if (ex_redir_valid)      nxt = ex_redir_target & ~64'd3;
      else if (m_vld && req_ready)  nxt = m_next_fetch();
      if (upd_valid) begin
        k = slot(upd_pc);
        if (upd_taken) begin
          m_bpc[k]  = upd_pc;
          m_btgt[k] = upd_target;
        end else if (owns(upd_pc)) begin
          m_bpc.delete(k);
          m_btgt.delete(k);
        end
      end
      m_pc  = nxt;
      m_vld = 1'b1;
    end
  endtask

  typedef struct {
    logic        vld;
    logic [63:0] pc;
    logic        pt;
    logic [63:0] ptgt;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic push_exp();
    exp_t e;
    e.vld  = m_vld;
    e.pc   = m_pc;
    e.pt   = owns(m_pc);
    e.ptgt = m_next_fetch();
    e.fl   = trap_valid || ex_redir_valid;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus with the currently driven inputs.
  task automatic cycle();
    push_exp();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    trap_valid = 0; ex_redir_valid = 0; upd_valid = 0; upd_taken = 0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      pops++;
      chk("sb_req_valid",    {63'd0, req_valid},      {63'd0, mon_e.vld});
      chk("sb_req_pc",       req_pc,                  mon_e.pc);
      chk("sb_pred_taken",   {63'd0, req_pred_taken}, {63'd0, mon_e.pt});
      chk("sb_pred_target",  req_pred_target,         mon_e.ptgt);
      chk("sb_flush",        {63'd0, flush},          {63'd0, mon_e.fl});
    end
  end

  initial begin
    rst = 1; req_ready = 0; trap_target = 0; ex_redir_target = 0; upd_pc = 0; upd_target = 0;
    idle();
    rst32 = 1; ready32 = 1; ex32_valid = 0; ex32_target = 0;

    // 32-bit wrap and mid-stream reset
    @(posedge clk); @(posedge clk); #1;
    chk("w32_rst_pc",   {32'd0, pc32},  64'h8000_0000);
    chk("w32_rst_vld",  {63'd0, v32},   64'd0);
    chk("w32_rst_ptgt", {32'd0, ptg32}, 64'h8000_0004);
    rst32 = 0; ex32_valid = 1; ex32_target = 32'hFFFF_FFFF; #1;
    chk("w32_flush", {63'd0, fl32}, 64'd1);
    @(posedge clk); #1; ex32_valid = 0; #1;
    chk("w32_redir_pc", {32'd0, pc32},  64'hFFFF_FFFC);
    chk("w32_vld",      {63'd0, v32},   64'd1);
    chk("w32_wrap_tgt", {32'd0, ptg32}, 64'h0);
    @(posedge clk); #1;
    chk("w32_wrap_pc", {32'd0, pc32}, 64'h0);
    rst32 = 1; ex32_valid = 1; ex32_target = 32'h1000;
    @(posedge clk); #1;
    chk("w32_midrst_pc",  {32'd0, pc32}, 64'h8000_0000);
    chk("w32_midrst_vld", {63'd0, v32},  64'd0);
    ex32_valid = 0;

    // 64-bit: establish model at a reset edge, then scoreboard every cycle
    @(posedge clk); model_step(); #1;
    cycle();
    chk("rst_pc",  req_pc, START);
    chk("rst_vld", {63'd0, req_valid}, 64'd0);
    rst = 0; req_ready = 1;
    cycle();
    chk("first_vld", {63'd0, req_valid}, 64'd1);
    chk("first_pc",  req_pc, START);
    cycle(); chk("seq_pc4", req_pc, START + 64'h4);
    cycle(); chk("seq_pc8", req_pc, START + 64'h8);
    cycle(); chk("seq_pcC", req_pc, START + 64'hC);

    upd_valid = 1; upd_taken = 1; upd_pc = START + 64'h8; upd_target = START + 64'h100;
    cycle(); idle();
    ex_redir_valid = 1; ex_redir_target = START;
    cycle(); idle();
    chk("btb_redir_pc", req_pc, START);
    cycle(); chk("btb_pc4", req_pc, START + 64'h4);
    cycle();
    chk("btb_pc8",      req_pc, START + 64'h8);
    chk("btb_pt_hit",   {63'd0, req_pred_taken}, 64'd1);
    chk("btb_pt_tgt",   req_pred_target, START + 64'h100);
    cycle(); chk("btb_jump_pc", req_pc, START + 64'h100);

    req_ready = 0;
    cycle(); cycle(); cycle();
    chk("stall_pc",  req_pc, START + 64'h100);
    chk("stall_vld", {63'd0, req_valid}, 64'd1);
    ex_redir_valid = 1; ex_redir_target = START + 64'h203; #1;
    chk("stall_flush", {63'd0, flush}, 64'd1);
    cycle(); idle();
    chk("stall_redir_pc", req_pc, START + 64'h200);

    req_ready = 1; trap_valid = 1; trap_target = START + 64'h40;
    ex_redir_valid = 1; ex_redir_target = START + 64'h300;
    cycle(); idle(); #1;
    chk("trap_wins_pc", req_pc, START + 64'h40);
    chk("trap_flush_done", {63'd0, flush}, 64'd0);

    upd_valid = 1; upd_taken = 0; upd_pc = START + 64'h28; upd_target = 0;
    cycle(); idle();
    req_ready = 0; ex_redir_valid = 1; ex_redir_target = START + 64'h8;
    cycle(); idle();
    chk("alias_kept", {63'd0, req_pred_taken}, 64'd1);
    upd_valid = 1; upd_taken = 0; upd_pc = START + 64'h8;
    cycle(); idle();
    chk("clr_pt", {63'd0, req_pred_taken}, 64'd0);
    chk("clr_tgt", req_pred_target, START + 64'hC);

    req_ready = 1; ex_redir_valid = 1; ex_redir_target = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle(); idle();
    chk("wrap64_tgt", req_pred_target, 64'h0);
    cycle();
    chk("wrap64_pc", req_pc, 64'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req_ready       = ($urandom_range(0, 3) != 0);
      trap_valid      = ($urandom_range(0, 31) == 0);
      trap_target     = START + 64'(4 * $urandom_range(0, 63)) + 64'($urandom_range(0, 3));
      ex_redir_valid  = ($urandom_range(0, 15) == 0);
      ex_redir_target = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE :
                        START + 64'(4 * $urandom_range(0, 63)) + 64'($urandom_range(0, 3));
      upd_valid       = ($urandom_range(0, 3) == 0);
      upd_pc          = ($urandom_range(0, 1) == 0) ? m_pc : START + 64'(4 * $urandom_range(0, 63));
      upd_target      = START + 64'(4 * $urandom_range(0, 63));
      upd_taken       = ($urandom_range(0, 2) != 0);
      rst             = ($urandom_range(0, 199) == 0);
      cycle();
    end

    // Reset overriding a redirect and a BTB update
    rst = 1; req_ready = 1; upd_valid = 1; upd_taken = 1; upd_pc = START; upd_target = START + 64'h500;
    ex_redir_valid = 1; ex_redir_target = START + 64'h700;
    cycle(); idle();
    chk("midrst_pc",  req_pc, START);
    chk("midrst_vld", {63'd0, req_valid}, 64'd0);
    rst = 0;
    cycle();
    chk("midrst_btb_empty", {63'd0, req_pred_taken}, 64'd0);
    cycle();
    chk("midrst_seq_pc", req_pc, START + 64'h4);

    req_ready = 0;
    cycle();
    @(negedge clk); #1;
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    checks++;
    if (pops < 3000) begin
      errors++;
      $display("FAIL sb_pop_count actual=%0d expected_at_least=3000", pops);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
